// File: rtl/irq_trap_controller.sv
// irq_trap_controller: machine-mode interrupt/trap controller.
// Synchronises NUM_IRQ external lines, tracks level/edge pending state,
// picks the lowest-index enabled source and runs a req/ack trap handshake
// with mret return sequencing toward the fetch stage.
// Optional build macro: IRQ_VECTORED_MODE_EN enables vectored mtvec mode 1.
module irq_trap_controller #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [15:0] EDGE_MASK   = 16'h0000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic               csr_wen,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  input  logic [31:0]        pc_in,
  output logic               trap_req,
  input  logic               trap_ack,
  input  logic               mret,
  output logic [31:0]        pc_out,
  output logic               pc_valid
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [NUM_IRQ-1:0] EDGE_BITS = EDGE_MASK[NUM_IRQ-1:0];

`ifdef IRQ_VECTORED_MODE_EN
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_out;
  logic [NUM_IRQ-1:0] sync_prev;
  logic [NUM_IRQ-1:0] edge_pend;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] claim;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] mie_bits;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;

  logic [4:0]  winner;
  logic [4:0]  cause_code;
  logic [31:0] vector;
  logic [31:0] mie_word;
  logic [31:0] mip_word;
  logic        take_trap;
  logic        do_return;
  logic        hw_status_upd;

  // Shift raw lines through the synchroniser chain and remember the last output for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sync_prev <= '0;
    end else begin
      sync_q[0] <= irq_lines;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sync_prev <= sync_out;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~sync_prev;

  // Edge sources latch a rising edge and hold it until claimed; a coincident edge re-sets the bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_pend <= '0;
    end else begin
      edge_pend <= ((edge_pend & ~claim) | rise) & EDGE_BITS;
    end
  end

  assign pending  = (edge_pend & EDGE_BITS) | (sync_out & ~EDGE_BITS);
  assign eligible = pending & mie_bits;

  // Fixed priority: the lowest-index eligible source wins
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 5'(i);
    end
  end

  assign cause_code = 5'd16 + winner;
  assign claim      = take_trap ? (NUM_IRQ'(1) << winner) : '0;

  // Trap target: direct base, or base plus 4*cause when vectored mode 1 is built in and selected
  always_comb begin
    vector = {mtvec_q[31:2], 2'b00};
`ifdef IRQ_VECTORED_MODE_EN
    if (mtvec_q[1:0] == 2'b01) begin
      vector = {mtvec_q[31:2], 2'b00} + {25'd0, cause_code, 2'b00};
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: request when enabled, withdraw if nothing stays eligible, return on mret
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mstatus_mie && (|eligible)) state_d = REQ;
      end
      REQ: begin
        if (!(|eligible))  state_d = IDLE;
        else if (trap_ack) state_d = HANDLER;
      end
      HANDLER: begin
        if (mret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: strobes for trap entry and return (mret in REQ and ack outside REQ are ignored)
  always_comb begin
    take_trap     = (state_q == REQ) && trap_ack && (|eligible);
    do_return     = mret && ((state_q == HANDLER) || (state_q == IDLE));
    hw_status_upd = take_trap || do_return;
  end

  // Registered handshake and redirect outputs toward fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_req <= 1'b0;
      pc_valid <= 1'b0;
      pc_out   <= '0;
    end else begin
      trap_req <= (state_d == REQ);
      pc_valid <= hw_status_upd;
      if (take_trap)      pc_out <= vector;
      else if (do_return) pc_out <= mepc_q;
    end
  end

  // mstatus: hardware trap entry/return take priority over a software write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (take_trap) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (do_return) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_wen && (csr_addr == ADDR_MSTATUS)) begin
      mstatus_mie  <= csr_wdata[3];
      mstatus_mpie <= csr_wdata[7];
    end
  end

  // mepc/mcause capture on trap entry, otherwise software-writable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (take_trap) begin
      mepc_q   <= pc_in & 32'hFFFF_FFFC;
      mcause_q <= {1'b1, 26'd0, cause_code};
    end else if (csr_wen) begin
      if (csr_addr == ADDR_MEPC)   mepc_q   <= csr_wdata & 32'hFFFF_FFFC;
      if (csr_addr == ADDR_MCAUSE) mcause_q <= csr_wdata;
    end
  end

  // Plain software-owned CSRs: mie, mtvec, mscratch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_bits   <= '0;
      mtvec_q    <= RESET_MTVEC & MTVEC_MASK;
      mscratch_q <= '0;
    end else if (csr_wen) begin
      if (csr_addr == ADDR_MIE)      mie_bits   <= csr_wdata[16 +: NUM_IRQ];
      if (csr_addr == ADDR_MTVEC)    mtvec_q    <= csr_wdata & MTVEC_MASK;
      if (csr_addr == ADDR_MSCRATCH) mscratch_q <= csr_wdata;
    end
  end

  // Place the per-source enable and pending vectors at bit 16 upward
  always_comb begin
    mie_word = '0;
    mip_word = '0;
    mie_word[16 +: NUM_IRQ] = mie_bits;
    mip_word[16 +: NUM_IRQ] = pending;
  end

  // Combinational CSR read; unlisted addresses read zero
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS:  csr_rdata = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      ADDR_MIE:      csr_rdata = mie_word;
      ADDR_MTVEC:    csr_rdata = mtvec_q;
      ADDR_MSCRATCH: csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_rdata = mepc_q;
      ADDR_MCAUSE:   csr_rdata = mcause_q;
      ADDR_MIP:      csr_rdata = mip_word;
      default:       csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_trap_controller.sv
// tb_irq_trap_controller: directed bench for irq_trap_controller.
// Expected redirect targets are queued as stimulus is issued; a monitor
// pops and compares each pc_valid pulse. CSR and trap_req values are
// checked directly against hand-computed constants.
module tb_irq_trap_controller;

  localparam int NUM_IRQ = 8;

`ifdef IRQ_VECTORED_MODE_EN
  localparam logic [31:0] EXP_MTVEC_RD = 32'h0000_0201;
  localparam logic [31:0] EXP_VEC_PC   = 32'h0000_0240;
`else
  localparam logic [31:0] EXP_MTVEC_RD = 32'h0000_0200;
  localparam logic [31:0] EXP_VEC_PC   = 32'h0000_0200;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_IRQ-1:0] irq_lines = '0;
  logic               csr_wen = 1'b0;
  logic [11:0]        csr_addr = '0;
  logic [31:0]        csr_wdata = '0;
  logic [31:0]        csr_rdata;
  logic [31:0]        pc_in = '0;
  logic               trap_req;
  logic               trap_ack = 1'b0;
  logic               mret = 1'b0;
  logic [31:0]        pc_out;
  logic               pc_valid;

  logic [31:0] exp_q [$];
  bit          mon_results [$];
  logic [31:0] mon_exp;
  int          total = 0;
  int          bad = 0;

  irq_trap_controller #(
    .NUM_IRQ     (NUM_IRQ),
    .EDGE_MASK   (16'h0008),
    .SYNC_STAGES (2),
    .RESET_MTVEC (32'h0000_0100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_lines (irq_lines),
    .csr_wen   (csr_wen),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .pc_in     (pc_in),
    .trap_req  (trap_req),
    .trap_ack  (trap_ack),
    .mret      (mret),
    .pc_out    (pc_out),
    .pc_valid  (pc_valid)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Monitor: every pc_valid pulse must match the oldest queued redirect target
  always @(negedge clk) begin
    if (rst_n && pc_valid) begin
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL pc_valid_unexpected: got pc_out=%h, required no pulse", pc_out);
        mon_results.push_back(1'b0);
      end else begin
        mon_exp = exp_q.pop_front();
        if (pc_out !== mon_exp) begin
          $display("[TB] FAIL pc_out: got %h, required %h", pc_out, mon_exp);
          mon_results.push_back(1'b0);
        end else begin
          mon_results.push_back(1'b1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic drain_monitor();
    bit ok;
    while (mon_results.size() > 0) begin
      ok = mon_results.pop_front();
      total++;
      if (!ok) bad++;
    end
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_wen   = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    tick(1);
    csr_wen   = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [11:0] addr, input logic [31:0] expected);
    csr_addr = addr;
    #1;
    check_output(name, csr_rdata, expected);
  endtask

  task automatic wait_trap_req(input string name);
    int n;
    n = 0;
    while (trap_req !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check_output(name, 32'(trap_req), 32'd1);
  endtask

  task automatic pulse_ack(input logic [31:0] pc, input logic [31:0] exp_target);
    exp_q.push_back(exp_target);
    pc_in    = pc;
    trap_ack = 1'b1;
    tick(1);
    trap_ack = 1'b0;
  endtask

  task automatic pulse_mret(input logic [31:0] exp_target);
    exp_q.push_back(exp_target);
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
  endtask

  // Directed stimulus sequence
  initial begin
    $display("[TB] start");
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    check_output("rst_trap_req", 32'(trap_req), 32'd0);
    check_output("rst_pc_valid", 32'(pc_valid), 32'd0);
    check_output("rst_pc_out", pc_out, 32'd0);
    read_check("rst_mstatus", 12'h300, 32'h0000_1800);
    read_check("rst_mtvec", 12'h305, 32'h0000_0100);
    read_check("rst_mip", 12'h344, 32'h0000_0000);
    read_check("unlisted_csr", 12'h7C0, 32'h0000_0000);

    // Level source 1: latency, capture and vector
    csr_write(12'h304, 32'h0002_0000);
    csr_write(12'h300, 32'h0000_0008);
    csr_write(12'h305, 32'h0000_0200);
    read_check("mie_rd", 12'h304, 32'h0002_0000);
    tick(1);
    irq_lines[1] = 1'b1;
    tick(2);
    check_output("lat_before", 32'(trap_req), 32'd0);
    tick(1);
    check_output("lat_at_3", 32'(trap_req), 32'd1);
    pulse_ack(32'h0000_1237, 32'h0000_0200);
    check_output("req_after_ack", 32'(trap_req), 32'd0);
    read_check("mepc_trap1", 12'h341, 32'h0000_1234);
    read_check("mcause_trap1", 12'h342, 32'h8000_0011);
    read_check("mstatus_trap1", 12'h300, 32'h0000_1880);
    irq_lines[1] = 1'b0;
    tick(4);
    pulse_mret(32'h0000_1234);
    read_check("mstatus_mret1", 12'h300, 32'h0000_1888);
    tick(1);
    drain_monitor();

    // Priority: sources 2 and 5 both pending
    csr_write(12'h304, 32'h0024_0000);
    irq_lines[2] = 1'b1;
    irq_lines[5] = 1'b1;
    wait_trap_req("wait_prio");
    pulse_ack(32'h0000_2000, 32'h0000_0200);
    read_check("mcause_prio2", 12'h342, 32'h8000_0012);
    irq_lines[2] = 1'b0;
    tick(4);
    pulse_mret(32'h0000_2000);
    wait_trap_req("wait_src5");
    pulse_ack(32'h0000_3000, 32'h0000_0200);
    read_check("mcause_prio5", 12'h342, 32'h8000_0015);
    irq_lines[5] = 1'b0;
    tick(4);
    pulse_mret(32'h0000_3000);
    tick(1);
    drain_monitor();

    // Edge source 3: latched while MIE=0, cleared on claim
    csr_write(12'h300, 32'h0000_0000);
    csr_write(12'h304, 32'h0008_0000);
    irq_lines[3] = 1'b1;
    tick(1);
    irq_lines[3] = 1'b0;
    tick(5);
    read_check("mip_edge_held", 12'h344, 32'h0008_0000);
    check_output("edge_no_req", 32'(trap_req), 32'd0);
    csr_write(12'h300, 32'h0000_0008);
    wait_trap_req("wait_edge");
    pulse_ack(32'h0000_4000, 32'h0000_0200);
    read_check("mip_edge_clr", 12'h344, 32'h0000_0000);
    read_check("mcause_edge", 12'h342, 32'h8000_0013);
    tick(1);
    pulse_mret(32'h0000_4000);
    tick(1);
    drain_monitor();

    // Level line dropped in REQ before ack: request withdrawn
    csr_write(12'h304, 32'h0001_0000);
    irq_lines[0] = 1'b1;
    wait_trap_req("wait_drop");
    irq_lines[0] = 1'b0;
    tick(4);
    check_output("drop_req_low", 32'(trap_req), 32'd0);
    pc_in    = 32'h0000_9000;
    trap_ack = 1'b1;
    tick(1);
    trap_ack = 1'b0;
    tick(2);
    read_check("drop_mepc", 12'h341, 32'h0000_4000);
    drain_monitor();

    // mtvec mode 1: vectored when built in, otherwise direct
    csr_write(12'h305, 32'h0000_0201);
    read_check("mtvec_mode", 12'h305, EXP_MTVEC_RD);
    irq_lines[0] = 1'b1;
    wait_trap_req("wait_vec");
    pulse_ack(32'h0000_5000, EXP_VEC_PC);
    irq_lines[0] = 1'b0;
    tick(4);
    pulse_mret(32'h0000_5000);
    tick(1);
    drain_monitor();

    // Asynchronous reset while a request is outstanding
    irq_lines[0] = 1'b1;
    wait_trap_req("wait_rst");
    rst_n = 1'b0;
    #2;
    check_output("midrst_trap_req", 32'(trap_req), 32'd0);
    check_output("midrst_pc_valid", 32'(pc_valid), 32'd0);
    check_output("midrst_pc_out", pc_out, 32'd0);
    read_check("midrst_mstatus", 12'h300, 32'h0000_1800);
    read_check("midrst_mepc", 12'h341, 32'h0000_0000);
    read_check("midrst_mtvec", 12'h305, 32'h0000_0100);
    irq_lines[0] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    drain_monitor();

    check_output("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
